// File: rtl/palette_ctl.sv
// palette_ctl: programmable 16-entry palette with a CPU write sequencer and a registered
// 6-bit RGB lookup for the VDP pixel path.
// Optional readback port enabled by defining PALETTE_READBACK_EN.
module palette_ctl #(
  parameter int unsigned DEFAULT_LOAD = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       idx_wr,
  input  logic       data_wr,
  input  logic [7:0] din,
  input  logic [3:0] color,
  input  logic       blank,
  output logic [1:0] red,
  output logic [1:0] grn,
  output logic [1:0] blu
`ifdef PALETTE_READBACK_EN
  ,
  input  logic       data_rd,
  output logic [7:0] dout
`endif
);

  typedef enum logic [0:0] {StFirst, StSecond} phase_e;

  // Fixed TI99 mapping, packed as {r,g,b}.
  function automatic logic [5:0] default_entry(input logic [3:0] i);
    logic [5:0] e;
    unique case (i)
      4'h0: e = 6'b00_00_00;
      4'h1: e = 6'b00_00_00;
      4'h2: e = 6'b00_10_00;
      4'h3: e = 6'b00_11_00;
      4'h4: e = 6'b00_00_01;
      4'h5: e = 6'b00_00_11;
      4'h6: e = 6'b01_00_00;
      4'h7: e = 6'b00_11_11;
      4'h8: e = 6'b10_00_00;
      4'h9: e = 6'b11_00_00;
      4'ha: e = 6'b01_01_00;
      4'hb: e = 6'b11_11_00;
      4'hc: e = 6'b00_01_00;
      4'hd: e = 6'b11_00_11;
      4'he: e = 6'b01_01_01;
      default: e = 6'b11_11_11;
    endcase
    return e;
  endfunction

  logic [5:0] pal_q [16];
  logic [3:0] index_q, index_d;
  phase_e     phase_q, phase_d;
  logic [7:0] hold_q, hold_d;
  logic [5:0] rgb_q;
  logic       commit;
  logic [5:0] commit_val;
  logic       rd_req;

`ifdef PALETTE_READBACK_EN
  logic [7:0] dout_q, dout_d;
  assign rd_req = data_rd;
`else
  assign rd_req = 1'b0;
`endif

  // Only the top two bits of each 3-bit colour field are kept.
  logic unused_bits;
  assign unused_bits = ^{din[7], din[4], hold_q[7], hold_q[4], hold_q[3], hold_q[0]};

  // Write/read sequencer: idx_wr beats data_wr, data_wr beats data_rd.
  always_comb begin
    index_d    = index_q;
    phase_d    = phase_q;
    hold_d     = hold_q;
    commit     = 1'b0;
    commit_val = {hold_q[6:5], din[2:1], hold_q[2:1]};
`ifdef PALETTE_READBACK_EN
    dout_d     = dout_q;
`endif
    if (idx_wr) begin
      index_d = din[3:0];
      phase_d = StFirst;
    end else if (data_wr) begin
      if (phase_q == StFirst) begin
        hold_d  = din;
        phase_d = StSecond;
      end else begin
        commit  = 1'b1;
        index_d = index_q + 4'd1;
        phase_d = StFirst;
      end
    end else if (rd_req) begin
      if (phase_q == StFirst) begin
        phase_d = StSecond;
`ifdef PALETTE_READBACK_EN
        dout_d  = {1'b0, pal_q[index_q][5:4], 2'b00, pal_q[index_q][1:0], 1'b0};
`endif
      end else begin
        index_d = index_q + 4'd1;
        phase_d = StFirst;
`ifdef PALETTE_READBACK_EN
        dout_d  = {5'b0, pal_q[index_q][3:2], 1'b0};
`endif
      end
    end
  end

  // Sequencer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q <= 4'd0;
      phase_q <= StFirst;
      hold_q  <= 8'd0;
    end else begin
      index_q <= index_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end

  // Palette storage; reset loads the TI99 table or clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= (DEFAULT_LOAD != 0) ? default_entry(4'(i)) : 6'd0;
      end
    end else if (commit) begin
      pal_q[index_q] <= commit_val;
    end
  end

  // Pixel lookup; a same-clock commit shows up from the next lookup on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q <= 6'd0;
    end else if (blank) begin
      rgb_q <= 6'd0;
    end else begin
      rgb_q <= pal_q[color];
    end
  end

  assign red = rgb_q[5:4];
  assign grn = rgb_q[3:2];
  assign blu = rgb_q[1:0];

`ifdef PALETTE_READBACK_EN
  // Readback data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= 8'd0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_palette_ctl.sv
// Directed self-checking bench for palette_ctl.
module tb_palette_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       idx_wr;
  logic       data_wr;
  logic [7:0] din;
  logic [3:0] color;
  logic       blank;
  logic [1:0] red, grn, blu;
`ifdef PALETTE_READBACK_EN
  logic       data_rd;
  logic [7:0] dout;
`endif

  int checks = 0;
  int errors = 0;

  logic [5:0] def_tbl [16];

  palette_ctl #(.DEFAULT_LOAD(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .idx_wr  (idx_wr),
    .data_wr (data_wr),
    .din     (din),
    .color   (color),
    .blank   (blank),
    .red     (red),
    .grn     (grn),
    .blu     (blu)
`ifdef PALETTE_READBACK_EN
    ,
    .data_rd (data_rd),
    .dout    (dout)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_idx(input logic [7:0] v);
    idx_wr = 1'b1;
    din    = v;
    tick();
    idx_wr = 1'b0;
  endtask

  task automatic wr_data(input logic [7:0] v);
    data_wr = 1'b1;
    din     = v;
    tick();
    data_wr = 1'b0;
  endtask

  // Present a colour and check the registered lookup one clock later.
  task automatic look(input string tag, input logic [3:0] c, input logic [5:0] exp);
    color = c;
    tick();
    check(tag, {2'b00, red, grn, blu}, {2'b00, exp});
  endtask

  initial begin
    def_tbl = '{6'b000000, 6'b000000, 6'b001000, 6'b001100,
                6'b000001, 6'b000011, 6'b010000, 6'b001111,
                6'b100000, 6'b110000, 6'b010100, 6'b111100,
                6'b000100, 6'b110011, 6'b010101, 6'b111111};
    reset   = 1'b0;
    idx_wr  = 1'b0;
    data_wr = 1'b0;
    din     = 8'h00;
    color   = 4'hd;
    blank   = 1'b0;
`ifdef PALETTE_READBACK_EN
    data_rd = 1'b0;
`endif
    tick();
    tick();
    check("reset_rgb", {2'b00, red, grn, blu}, 8'h00);
`ifdef PALETTE_READBACK_EN
    check("reset_dout", dout, 8'h00);
`endif
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Default table sweep.
    for (int i = 0; i < 16; i++) begin
      look($sformatf("default_%0h", i), 4'(i), def_tbl[i]);
    end

    // Entry 5 <- r3 g3 b0; the index auto-increments to 6.
    wr_idx(8'h05);
    wr_data(8'h71);
    wr_data(8'h06);
    look("entry5", 4'h5, 6'b11_11_00);
    wr_data(8'h20);
    wr_data(8'h02);
    look("entry6_autoinc", 4'h6, 6'b01_01_00);
    look("entry7_untouched", 4'h7, 6'b00_11_11);

    // Wrap from f to 0.
    wr_idx(8'h0f);
    wr_data(8'h00);
    wr_data(8'h00);
    wr_data(8'h40);
    wr_data(8'h04);
    look("entryf", 4'hf, 6'b00_00_00);
    look("entry0_wrap", 4'h0, 6'b10_10_00);
    look("entry1_untouched", 4'h1, 6'b00_00_00);

    // Half-written entry discarded by idx_wr.
    wr_data(8'h44);
    wr_idx(8'h02);
    wr_data(8'h70);
    wr_data(8'h07);
    look("entry2_discard", 4'h2, 6'b11_11_00);

    // idx_wr and data_wr together: index loads, data ignored.
    idx_wr  = 1'b1;
    data_wr = 1'b1;
    din     = 8'h03;
    tick();
    idx_wr  = 1'b0;
    data_wr = 1'b0;
    look("entry3_before", 4'h3, 6'b00_11_00);
    wr_data(8'h07);
    // Commit on the same clock the lookup reads entry 3.
    color   = 4'h3;
    data_wr = 1'b1;
    din     = 8'h00;
    tick();
    data_wr = 1'b0;
    check("collision_old", {2'b00, red, grn, blu}, {2'b00, 6'b00_11_00});
    tick();
    check("collision_new", {2'b00, red, grn, blu}, {2'b00, 6'b00_00_11});
    blank = 1'b1;
    tick();
    check("blank", {2'b00, red, grn, blu}, 8'h00);
    blank = 1'b0;
    tick();
    check("unblank", {2'b00, red, grn, blu}, {2'b00, 6'b00_00_11});
    look("entry4_untouched", 4'h4, 6'b00_00_01);

`ifdef PALETTE_READBACK_EN
    wr_idx(8'h0d);
    data_rd = 1'b1;
    tick();
    check("rd_d_first", dout, 8'h66);
    tick();
    check("rd_d_second", dout, 8'h00);
    tick();
    check("rd_e_first", dout, 8'h22);
    tick();
    check("rd_e_second", dout, 8'h02);
    // Read alongside a write: write wins, dout holds.
    data_wr = 1'b1;
    din     = 8'h77;
    tick();
    data_wr = 1'b0;
    data_rd = 1'b0;
    check("rd_wr_hold", dout, 8'h02);
    wr_data(8'h00);
    look("entryf_rw", 4'hf, 6'b11_00_11);
    // idx_wr beats data_rd.
    idx_wr  = 1'b1;
    data_rd = 1'b1;
    din     = 8'h03;
    tick();
    idx_wr  = 1'b0;
    check("idx_beats_rd", dout, 8'h02);
    tick();
    data_rd = 1'b0;
    check("rd_3_first", dout, 8'h06);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
